// File: rtl/apple_arbiter.sv
// apple_arbiter: owns the single shared apple in the two-snake game.
// Spawns each apple at a pseudo-random legal cell, detects which alive head
// reaches it, arbitrates simultaneous arrivals round-robin and issues a
// one-cycle eat grant to the winner.
// Optional build macro: APPLE_TIMEOUT_EN (apple expires after TIMEOUT_CYCLES
// ACTIVE cycles and respawns without a grant).
module apple_arbiter #(
  parameter int unsigned GRID_W         = 80,
  parameter int unsigned GRID_H         = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gameOver,
  input  logic [1:0] alive,
  input  logic [6:0] snake0X,
  input  logic [6:0] snake0Y,
  input  logic [6:0] snake1X,
  input  logic [6:0] snake1Y,
  output logic [6:0] appleX,
  output logic [6:0] appleY,
  output logic       appleValid,
  output logic [1:0] eat,
  output logic [7:0] spawnCount
);

  typedef enum logic [1:0] {
    SPAWN  = 2'd0,
    ACTIVE = 2'd1,
    GRANT  = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [7:0] GRID_W8 = 8'(GRID_W);
  localparam logic [7:0] GRID_H8 = 8'(GRID_H);

  state_t      state;
  state_t      state_nx;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        rr_ptr;
  logic        rr_ptr_nx;
  logic [6:0]  apple_x_nx;
  logic [6:0]  apple_y_nx;
  logic        apple_valid_nx;
  logic [1:0]  eat_nx;
  logic [7:0]  spawn_count_nx;

  logic [6:0]  cand_x;
  logic [6:0]  cand_y;
  logic        cand_in_grid;
  logic        cand_on_head0;
  logic        cand_on_head1;
  logic        cand_legal;
  logic        hit0;
  logic        hit1;

`ifdef APPLE_TIMEOUT_EN
  localparam logic [19:0] LIFE_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] life_cnt;
  logic [19:0] life_cnt_nx;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

  // Fibonacci feedback, taps 16,14,13,11 (bits 15,13,12,10).
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  assign cand_x = lfsr[6:0];
  assign cand_y = lfsr[14:8];

  assign cand_in_grid  = ({1'b0, cand_x} < GRID_W8) && ({1'b0, cand_y} < GRID_H8);
  assign cand_on_head0 = alive[0] && (cand_x == snake0X) && (cand_y == snake0Y);
  assign cand_on_head1 = alive[1] && (cand_x == snake1X) && (cand_y == snake1Y);
  assign cand_legal    = cand_in_grid && !cand_on_head0 && !cand_on_head1;

  assign hit0 = alive[0] && (snake0X == appleX) && (snake0Y == appleY);
  assign hit1 = alive[1] && (snake1X == appleX) && (snake1Y == appleY);

  // LFSR free-runs every non-reset cycle, HALT included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // State and all registered outputs; reset overrides any pending grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SPAWN;
      appleX     <= '0;
      appleY     <= '0;
      appleValid <= 1'b0;
      eat        <= '0;
      spawnCount <= '0;
      rr_ptr     <= 1'b0;
`ifdef APPLE_TIMEOUT_EN
      life_cnt   <= '0;
`endif
    end else begin
      state      <= state_nx;
      appleX     <= apple_x_nx;
      appleY     <= apple_y_nx;
      appleValid <= apple_valid_nx;
      eat        <= eat_nx;
      spawnCount <= spawn_count_nx;
      rr_ptr     <= rr_ptr_nx;
`ifdef APPLE_TIMEOUT_EN
      life_cnt   <= life_cnt_nx;
`endif
    end
  end

  // Next-state and next-output logic; gameOver pre-empts any same-cycle hit.
  always_comb begin
    state_nx       = state;
    apple_x_nx     = appleX;
    apple_y_nx     = appleY;
    apple_valid_nx = appleValid;
    eat_nx         = '0;
    spawn_count_nx = spawnCount;
    rr_ptr_nx      = rr_ptr;
`ifdef APPLE_TIMEOUT_EN
    life_cnt_nx    = life_cnt;
`endif

    if (gameOver) begin
      state_nx       = HALT;
      apple_valid_nx = 1'b0;
    end else begin
      case (state)
        SPAWN: begin
          if (cand_legal) begin
            apple_x_nx     = cand_x;
            apple_y_nx     = cand_y;
            apple_valid_nx = 1'b1;
            if (spawnCount != 8'hFF) begin
              spawn_count_nx = spawnCount + 8'd1;
            end
            state_nx       = ACTIVE;
`ifdef APPLE_TIMEOUT_EN
            life_cnt_nx    = '0;
`endif
          end
        end

        ACTIVE: begin
          if (hit0 && hit1) begin
            // Contested: rr_ptr names the winner, then flips.
            eat_nx         = rr_ptr ? 2'b10 : 2'b01;
            rr_ptr_nx      = ~rr_ptr;
            apple_valid_nx = 1'b0;
            state_nx       = GRANT;
          end else if (hit0) begin
            eat_nx         = 2'b01;
            apple_valid_nx = 1'b0;
            state_nx       = GRANT;
          end else if (hit1) begin
            eat_nx         = 2'b10;
            apple_valid_nx = 1'b0;
            state_nx       = GRANT;
          end else begin
`ifdef APPLE_TIMEOUT_EN
            if (life_cnt == LIFE_LAST) begin
              apple_valid_nx = 1'b0;
              state_nx       = SPAWN;
            end else begin
              life_cnt_nx = life_cnt + 20'd1;
            end
`endif
          end
        end

        GRANT: begin
          state_nx = SPAWN;
        end

        HALT: begin
          apple_valid_nx = 1'b0;
        end

        default: begin
          state_nx       = SPAWN;
          apple_valid_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apple_arbiter.sv
// Directed bench for apple_arbiter with a grant scoreboard: stimulus pushes
// the expected eat vector, a negedge monitor pops it when eat is asserted.
module tb_apple_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       gameOver = 1'b0;
  logic [1:0] alive = 2'b11;
  logic [6:0] snake0X = 7'd5;
  logic [6:0] snake0Y = 7'd5;
  logic [6:0] snake1X = 7'd6;
  logic [6:0] snake1Y = 7'd6;
  logic [6:0] appleX;
  logic [6:0] appleY;
  logic       appleValid;
  logic [1:0] eat;
  logic [7:0] spawnCount;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] expq[$];

  always #5 clk = ~clk;

  apple_arbiter #(
    .GRID_W(80),
    .GRID_H(60),
    .LFSR_SEED(16'hACE1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .gameOver(gameOver),
    .alive(alive),
    .snake0X(snake0X),
    .snake0Y(snake0Y),
    .snake1X(snake1X),
    .snake1Y(snake1Y),
    .appleX(appleX),
    .appleY(appleY),
    .appleValid(appleValid),
    .eat(eat),
    .spawnCount(spawnCount)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n;
    n = 0;
    while (!appleValid && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_valid_within_budget"}, int'(appleValid), 1);
  endtask

  task automatic check_apple(input string nm);
    chk({nm, "_x_in_grid"}, int'(appleX < 7'd80), 1);
    chk({nm, "_y_in_grid"}, int'(appleY < 7'd60), 1);
    chk({nm, "_not_on_head0"},
        int'(alive[0] && appleX == snake0X && appleY == snake0Y), 0);
    chk({nm, "_not_on_head1"},
        int'(alive[1] && appleX == snake1X && appleY == snake1Y), 0);
  endtask

  task automatic park_heads;
    snake0X = 7'd127; snake0Y = 7'd127;
    snake1X = 7'd126; snake1Y = 7'd126;
  endtask

  // Scoreboard monitor: every asserted grant must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && eat != 2'b00) begin
      chk("eat_onehot", $countones(eat), 1);
      chk("eat_while_valid", int'(appleValid), 0);
      if (expq.size() == 0) begin
        chk("unexpected_eat", int'(eat), 0);
      end else begin
        chk("eat_grant", int'(eat), int'(expq.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    // Reset held three cycles.
    repeat (3) begin
      tick();
      chk("rst_valid", int'(appleValid), 0);
      chk("rst_eat", int'(eat), 0);
      chk("rst_x", int'(appleX), 0);
      chk("rst_y", int'(appleY), 0);
      chk("rst_count", int'(spawnCount), 0);
    end
    reset = 1'b1;
    wait_valid("first_apple", 64);
    check_apple("first_apple");
    chk("first_count", int'(spawnCount), 1);

    // Single hit by snake0; head then lingers on the old cell.
    snake0X = appleX; snake0Y = appleY;
    expq.push_back(2'b01);
    tick();
    chk("single_valid_drop", int'(appleValid), 0);
    tick();
    chk("single_eat_one_cycle", int'(eat), 0);
    wait_valid("single_respawn", 200);
    check_apple("single_respawn");
    chk("single_count", int'(spawnCount), 2);
    repeat (3) tick();
    park_heads();

    // Three contests: round-robin gives 01, 10, 01.
    for (int k = 0; k < 3; k++) begin
      snake0X = appleX; snake0Y = appleY;
      snake1X = appleX; snake1Y = appleY;
      expq.push_back((k == 1) ? 2'b10 : 2'b01);
      tick();
      chk("contest_valid_drop", int'(appleValid), 0);
      tick();
      chk("contest_eat_one_cycle", int'(eat), 0);
      park_heads();
      wait_valid("contest_respawn", 200);
      chk("contest_count", int'(spawnCount), 3 + k);
    end

    // Dead snake0 sits on the apple: no grant; then alive snake1 eats.
    alive = 2'b10;
    snake0X = appleX; snake0Y = appleY;
    repeat (3) tick();
    chk("dead_no_grant_valid", int'(appleValid), 1);
    snake1X = appleX; snake1Y = appleY;
    expq.push_back(2'b10);
    tick();
    chk("alive1_valid_drop", int'(appleValid), 0);
    tick();
    park_heads();
    alive = 2'b11;
    wait_valid("alive1_respawn", 200);
    chk("alive1_count", int'(spawnCount), 6);

    // Reset on the same edge as a hit: no grant, everything cleared.
    snake0X = appleX; snake0Y = appleY;
    reset = 1'b0;
    tick();
    chk("rst_mid_eat", int'(eat), 0);
    chk("rst_mid_valid", int'(appleValid), 0);
    chk("rst_mid_count", int'(spawnCount), 0);
    reset = 1'b1;
    park_heads();
    wait_valid("rst_mid_respawn", 200);
    chk("rst_mid_new_count", int'(spawnCount), 1);

    // gameOver on the same cycle as a hit: HALT, no grant, absorbing.
    snake1X = appleX; snake1Y = appleY;
    gameOver = 1'b1;
    tick();
    chk("gameover_eat", int'(eat), 0);
    chk("gameover_valid", int'(appleValid), 0);
    gameOver = 1'b0;
    park_heads();
    repeat (100) begin
      tick();
      chk("halt_valid", int'(appleValid), 0);
      chk("halt_eat", int'(eat), 0);
    end
    chk("halt_count_frozen", int'(spawnCount), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_valid("after_halt", 200);
    chk("after_halt_count", int'(spawnCount), 1);

`ifdef APPLE_TIMEOUT_EN
    // Apple expires after 16 ACTIVE cycles with no grant, then respawns.
    for (int r = 0; r < 2; r++) begin
      base = int'(spawnCount);
      n = 1;
      while (appleValid && n < 100) begin
        tick();
        if (appleValid) n++;
      end
      chk("timeout_life_cycles", n, 16);
      wait_valid("timeout_respawn", 200);
      chk("timeout_count", int'(spawnCount), base + 1);
    end
`else
    base = 0;
    n = 0;
`endif

    repeat (2) tick();
    chk("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
